// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq (with cs_adder_32bit)
// Purpose  : Streaming multi-word adder. Each beat is one word of a wide
//            operand. The carry is chained from beat to beat, and each result
//            beat is registered with ready/valid handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// cs_adder_32bit: carry-select adder built from NIBBLE_SIZE-wide blocks.
// Each block precomputes its sum for carry-in 0 and for carry-in 1. The
// incoming block carry then picks one of the two results.
// If TOTAL_WIDTH is not a multiple of NIBBLE_SIZE, the operands are
// zero-padded. The carry out of TOTAL_WIDTH bits then appears as the first
// padded sum bit.
// ----------------------------------------------------------------------------
module cs_adder_32bit #(
  parameter int TOTAL_WIDTH = 32,
  parameter int NIBBLE_SIZE = 4
) (
  input  logic [TOTAL_WIDTH-1:0] a,
  input  logic [TOTAL_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [TOTAL_WIDTH-1:0] sum,
  output logic                   cout
);

  localparam int NUM_BLOCKS = (TOTAL_WIDTH + NIBBLE_SIZE - 1) / NIBBLE_SIZE;
  localparam int PAD_WIDTH  = NUM_BLOCKS * NIBBLE_SIZE;

  logic [PAD_WIDTH-1:0] a_pad;
  logic [PAD_WIDTH-1:0] b_pad;
  logic [PAD_WIDTH-1:0] sum_pad;
  logic [NUM_BLOCKS:0]  carry;
  logic [PAD_WIDTH:0]   sum_ext;

  assign a_pad    = PAD_WIDTH'(a);
  assign b_pad    = PAD_WIDTH'(b);
  assign carry[0] = cin;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_block
    logic [NIBBLE_SIZE:0] sum0;
    logic [NIBBLE_SIZE:0] sum1;

    // Both carry hypotheses are computed in parallel; the real carry selects one
    assign sum0 = {1'b0, a_pad[i*NIBBLE_SIZE +: NIBBLE_SIZE]}
                + {1'b0, b_pad[i*NIBBLE_SIZE +: NIBBLE_SIZE]};
    assign sum1 = {1'b0, a_pad[i*NIBBLE_SIZE +: NIBBLE_SIZE]}
                + {1'b0, b_pad[i*NIBBLE_SIZE +: NIBBLE_SIZE]}
                + {{NIBBLE_SIZE{1'b0}}, 1'b1};

    assign sum_pad[i*NIBBLE_SIZE +: NIBBLE_SIZE] =
      carry[i] ? sum1[NIBBLE_SIZE-1:0] : sum0[NIBBLE_SIZE-1:0];
    assign carry[i+1] = carry[i] ? sum1[NIBBLE_SIZE] : sum0[NIBBLE_SIZE];
  end

  // Bit TOTAL_WIDTH of the extended sum is the true carry-out, padded or not
  assign sum_ext = {carry[NUM_BLOCKS], sum_pad};
  assign sum     = sum_ext[TOTAL_WIDTH-1:0];
  assign cout    = sum_ext[TOTAL_WIDTH];

endmodule

// ----------------------------------------------------------------------------
// wide_add_seq: beat sequencer around the carry-select adder
// ----------------------------------------------------------------------------
module wide_add_seq #(
  parameter int TOTAL_WIDTH = 32,
  parameter int NIBBLE_SIZE = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [TOTAL_WIDTH-1:0] a_i,
  input  logic [TOTAL_WIDTH-1:0] b_i,
  input  logic                   cin_i,
  input  logic                   first_i,
  input  logic                   last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [TOTAL_WIDTH-1:0] sum_o,
  output logic                   last_o,
  output logic                   cout_o,
  output logic                   err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state;
  logic                   carry_q;
  logic                   accept;
  logic                   chain_start;
  logic                   add_cin;
  logic                   beat_err;
  logic [TOTAL_WIDTH-1:0] add_sum;
  logic                   add_cout;

  // The output register can take a new beat if it is empty or being drained
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;

  // A framing error still starts a new chain, so cin_i is used in both cases
  assign chain_start = (state == IDLE) || first_i;
  assign add_cin     = chain_start ? cin_i : carry_q;
  assign beat_err    = ((state == IDLE) && !first_i) || ((state == BUSY) && first_i);

  cs_adder_32bit #(
    .TOTAL_WIDTH (TOTAL_WIDTH),
    .NIBBLE_SIZE (NIBBLE_SIZE)
  ) u_adder (
    .a    (a_i),
    .b    (b_i),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Chain FSM, carry register and output register: all move only on an accepted beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      carry_q     <= 1'b0;
      out_valid_o <= 1'b0;
      sum_o       <= '0;
      cout_o      <= 1'b0;
      last_o      <= 1'b0;
      err_o       <= 1'b0;
    end else if (accept) begin
      state       <= last_i ? IDLE : BUSY;
      carry_q     <= add_cout;
      out_valid_o <= 1'b1;
      sum_o       <= add_sum;
      cout_o      <= add_cout;
      last_o      <= last_i;
      err_o       <= beat_err;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`timescale 1ns/1ps
module tb_wide_add_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         last;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         first;
  logic         last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         last_out;
  logic         cout;
  logic         err;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  wide_add_seq #(.TOTAL_WIDTH(W), .NIBBLE_SIZE(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .first_i     (first),
    .last_i      (last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .last_o      (last_out),
    .cout_o      (cout),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: pop and compare every result beat that is handed off
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_beat", 64'({sum, cout, last_out, err}), 64'(e));
      end
    end
  end

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                       input logic f, input logic l);
    in_valid = 1'b1;
    a = av; b = bv; cin = c; first = f; last = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Wait for the handshake of the driven beat; returns at posedge+1
  task automatic wait_accept(input logic [W-1:0] es, input logic ec, input logic el,
                             input logic ee, input bit push, output int stalls);
    int n;
    n = 0;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 64'(n), 64'(0));
        return;
      end
    end
    stalls = n;
    @(posedge clk);
    if (push) exp_q.push_back('{sum: es, cout: ec, last: el, err: ee});
    #1;
    check("latency_valid", 64'(out_valid), 64'(1));
  endtask

  initial begin
    int st;
    int stalls_total;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; first = 1'b0; last = 1'b0;

    // Reset state
    #2;
    check("rst_outputs", 64'({out_valid, sum, cout, last_out, err}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // 64-bit add, back to back
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    wait_accept(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1, st);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    wait_accept(32'h0000_0001, 1'b0, 1'b1, 1'b0, 1, st);

    // Single-beat add with carry-in
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1);
    wait_accept(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1, st);
    idle();
    @(posedge clk); #1;

    // Backpressure: beat1 held in output register for 3 cycles
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    wait_accept(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1, st);
    out_ready = 1'b0;
    drive(32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_hold", 64'({out_valid, sum, cout, last_out, err}), {28'(0), 1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept(32'h0000_0004, 1'b0, 1'b1, 1'b0, 1, st);

    // Framing errors: missing first in IDLE, then first mid-chain
    drive(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    wait_accept(32'h0000_0001, 1'b1, 1'b0, 1'b1, 1, st);
    drive(32'h2, 32'h3, 1'b0, 1'b1, 1'b0);
    wait_accept(32'h0000_0005, 1'b0, 1'b0, 1'b1, 1, st);
    drive(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1);
    wait_accept(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1, st);
    idle();
    @(posedge clk); #1;

    // Reset in the middle of a carry-generating chain
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    wait_accept(32'h0, 1'b0, 1'b0, 1'b0, 0, st);
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({out_valid, sum, cout, last_out, err}), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    drive(32'h1, 32'h1, 1'b0, 1'b1, 1'b1);
    wait_accept(32'h0000_0002, 1'b0, 1'b1, 1'b0, 1, st);

    // 128-bit random streaming at full throughput
    stalls_total = 0;
    for (int t = 0; t < 6; t++) begin
      logic [127:0] ra;
      logic [127:0] rb;
      logic         rc;
      logic [128:0] p;
      logic [128:0] mask;
      ra = (t == 0) ? {128{1'b1}} : {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = (t == 0) ? 128'd1      : {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = (t == 0) ? 1'b0 : 1'($urandom_range(1));
      for (int i = 0; i < 4; i++) begin
        mask = (129'(1) << (32 * (i + 1))) - 129'(1);
        p = ({1'b0, ra} & mask) + ({1'b0, rb} & mask) + 129'(rc);
        drive(ra[32*i +: 32], rb[32*i +: 32], rc, i == 0, i == 3);
        wait_accept(p[32*i +: 32], p[32*(i+1)], i == 3, 1'b0, 1, st);
        stalls_total += st;
      end
    end
    idle();
    check("stream_stalls", 64'(stalls_total), 64'(0));

    // Drain the scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter TOTAL_WIDTH, default 32, beat word width; it is passed to the adder datapath.
REQ-002 SHALL have parameter NIBBLE_SIZE, default 4, carry-select block size; it is passed to the adder datapath.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid_i, input, 1, input beat valid.
REQ-006 SHALL have port in_ready_o, output, 1, input beat ready.
REQ-007 SHALL have port a_i, input, TOTAL_WIDTH, operand A word of the beat.
REQ-008 SHALL have port b_i, input, TOTAL_WIDTH, operand B word of the beat.
REQ-009 SHALL have port cin_i, input, 1, carry-in, used only on a chain-start beat.
REQ-010 SHALL have port first_i, input, 1, beat is the least-significant word of an operand.
REQ-011 SHALL have port last_i, input, 1, beat is the most-significant word of an operand.
REQ-012 SHALL have port out_valid_o, output, 1, result beat valid.
REQ-013 SHALL have port out_ready_i, input, 1, result beat ready.
REQ-014 SHALL have port sum_o, output, TOTAL_WIDTH, sum word of the result beat.
REQ-015 SHALL have port last_o, output, 1, registered copy of last_i for the beat.
REQ-016 SHALL have port cout_o, output, 1, carry-out of the beat; it is the final carry when last_o=1.
REQ-017 SHALL have port err_o, output, 1, framing error flag for the beat.

Function
REQ-018 SHALL instantiate cs_adder_32bit as the sole adder for each beat; no other arithmetic on the datapath.
REQ-019 SHALL accept a beat when in_valid_i && in_ready_o at a rising edge.
REQ-020 SHALL drive in_ready_o = !out_valid_o || out_ready_i, combinationally.
REQ-021 SHALL register the result of an accepted beat into sum_o/cout_o/last_o/err_o and set out_valid_o at the accepting edge; latency 1 cycle.
REQ-022 SHALL sustain 1 beat/cycle while out_ready_i=1.
REQ-023 SHALL hold all output registers stable while out_valid_o=1 && out_ready_i=0.
REQ-024 SHALL clear out_valid_o on an edge with out_ready_i=1 and no accepted beat.
REQ-025 SHALL implement FSM states IDLE (awaiting chain start) and BUSY (mid-chain), plus a carry register carry_q.
REQ-026 SHALL use adder carry-in = cin_i when the beat starts a chain, else carry_q.
REQ-027 SHALL treat the beat as a chain start if state=IDLE or first_i=1.
REQ-028 SHALL load carry_q with the adder carry-out on every accepted beat.
REQ-029 SHALL transition IDLE->BUSY on an accepted beat with last_i=0, and stay in IDLE when last_i=1 (single-beat add).
REQ-030 SHALL transition BUSY->IDLE on an accepted beat with last_i=1, and stay in BUSY otherwise.
REQ-031 SHALL set err_o=1 for a beat accepted in IDLE with first_i=0; the beat is still processed as a chain start.
REQ-032 SHALL set err_o=1 for a beat accepted in BUSY with first_i=1; the chain restarts with cin_i.
REQ-033 SHALL set err_o=0 for all other beats.
REQ-034 SHALL keep state and carry_q unchanged on cycles with no accepted beat, including under backpressure.

Reset
REQ-035 SHALL, while rst_ni=0, force out_valid_o=0, sum_o=0, cout_o=0, last_o=0, err_o=0, state=IDLE and carry_q=0, asynchronously.
REQ-036 SHALL discard a partially accepted chain on reset, and SHALL start the first beat after reset release in IDLE.
REQ-037 SHALL drive in_ready_o=1 during reset and on the first cycle after reset release.

Verification
REQ-038 SHALL pass a 64-bit add: beat1 a=FFFFFFFF, b=00000001, cin=0, first=1; beat2 a=0, b=0, last=1 -> sum 00000000/cout 1, then sum 00000001/last 1/cout 0/err 0.
REQ-039 SHALL pass a single-beat add: a=FFFFFFFF, b=0, cin=1, first=1, last=1 -> sum 00000000, cout 1, last 1, one cycle later.
REQ-040 SHALL pass backpressure: with out_ready_i=0 for 3 cycles after beat1 -> in_ready_o=0 and outputs stable; beat2 is accepted only after out_ready_i=1, and the chained carry is correct.
REQ-041 SHALL pass a framing error: first=0 beat in IDLE -> err 1, with cin_i used; first=1 beat mid-chain -> err 1, chain restarted.
REQ-042 SHALL pass reset mid-chain: rst_ni low after beat1 of a carry-generating chain -> outputs zero; the next beat (first=1, cin=0, a=1, b=1) -> sum 00000002, cout 0.
REQ-043 SHALL pass a 128-bit random streaming test at full throughput: 4-beat sums and the final cout match a 128-bit reference model.
